// File: rtl/gpio_cond_pkg.sv
// Shared constants for the GPIO input conditioner: register offsets and reset values.
package gpio_cond_pkg;

  localparam int ADDR_IDX_W = 3;

  // Word offsets, decoded from bus_addr[4:2]
  localparam logic [ADDR_IDX_W-1:0] OFF_IN_RAW     = 3'd0;
  localparam logic [ADDR_IDX_W-1:0] OFF_IN_DEB     = 3'd1;
  localparam logic [ADDR_IDX_W-1:0] OFF_RISE_EN    = 3'd2;
  localparam logic [ADDR_IDX_W-1:0] OFF_FALL_EN    = 3'd3;
  localparam logic [ADDR_IDX_W-1:0] OFF_IRQ_EN     = 3'd4;
  localparam logic [ADDR_IDX_W-1:0] OFF_IRQ_STATUS = 3'd5;
  localparam logic [ADDR_IDX_W-1:0] OFF_BYPASS     = 3'd6;

  localparam logic [31:0] RST_REG   = 32'h0;
  localparam logic [31:0] RST_RDATA = 32'h0;
  localparam logic        RST_BIT   = 1'b0;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: two-flop synchroniser, tick-driven debounce counter and bypass mux.
module gpio_debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int DEB_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic bypass_i,
  input  logic pad_i,
  output logic sync_o,
  output logic deb_o
);

  localparam int CW = $clog2(DEB_SAMPLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);

  logic          meta_q, sync_q, deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (bypass_i) begin
      deb_d = sync_q;
      cnt_d = '0;
    end else if (tick_i) begin
      // Counter saturates at CNT_LAST by accepting and clearing, so it never wraps
      if (sync_q == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_d = sync_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_BIT;
      sync_q <= RST_BIT;
      deb_q  <= RST_BIT;
      cnt_q  <= '0;
    end else begin
      meta_q <= pad_i;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync_o = sync_q;
  assign deb_o  = deb_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Pad input conditioner: per-pin sync/debounce, edge detect, W1C status and level irq,
// behind a single-beat register bus.
module gpio_in_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int N_PINS      = 32,
  parameter int DEB_DIV     = 1000,
  parameter int DEB_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_valid,
  input  logic              bus_we,
  input  logic [31:0]       bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  input  logic [N_PINS-1:0] pad_in,
  output logic [N_PINS-1:0] gpio_deb,
  output logic              irq
);

  localparam int PW = $clog2(DEB_DIV);
  localparam logic [PW-1:0] PSC_LAST = PW'(DEB_DIV - 1);

  logic [PW-1:0] psc_q, psc_d;
  logic          tick;

  assign tick  = (psc_q == PSC_LAST);
  assign psc_d = tick ? '0 : psc_q + PW'(1);

  logic [N_PINS-1:0] sync, deb, deb_prev_q, rise, fall;
  logic [N_PINS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [N_PINS-1:0] irq_en_q, irq_en_d, status_q, status_d, bypass_q, bypass_d;
  logic [31:0]       rdata_q, rdata_d;

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    gpio_debounce_bit #(.DEB_SAMPLES(DEB_SAMPLES)) u_bit (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick),
      .bypass_i (bypass_q[i]),
      .pad_i    (pad_in[i]),
      .sync_o   (sync[i]),
      .deb_o    (deb[i])
    );
  end

  assign rise = deb & ~deb_prev_q;
  assign fall = ~deb & deb_prev_q;

  logic                  wr, rd;
  logic [ADDR_IDX_W-1:0] idx;
  logic [N_PINS-1:0]     wdat, w1c;

  assign wr   = bus_valid & bus_we;
  assign rd   = bus_valid & ~bus_we;
  assign idx  = bus_addr[4:2];
  assign wdat = bus_wdata[N_PINS-1:0];
  assign w1c  = (wr && idx == OFF_IRQ_STATUS) ? wdat : '0;

  logic unused_addr;
  assign unused_addr = ^{bus_addr[31:5], bus_addr[1:0]};
  if (N_PINS < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^bus_wdata[31:N_PINS];
  end

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    bypass_d  = bypass_q;
    // Set is OR'd in after the clear so a same-cycle edge survives a W1C
    status_d  = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    if (wr) begin
      case (idx)
        OFF_RISE_EN: rise_en_d = wdat;
        OFF_FALL_EN: fall_en_d = wdat;
        OFF_IRQ_EN:  irq_en_d  = wdat;
        OFF_BYPASS:  bypass_d  = wdat;
        default:     ;
      endcase
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (idx)
        OFF_IN_RAW:     rdata_d = 32'(sync);
        OFF_IN_DEB:     rdata_d = 32'(deb);
        OFF_RISE_EN:    rdata_d = 32'(rise_en_q);
        OFF_FALL_EN:    rdata_d = 32'(fall_en_q);
        OFF_IRQ_EN:     rdata_d = 32'(irq_en_q);
        OFF_IRQ_STATUS: rdata_d = 32'(status_q);
        OFF_BYPASS:     rdata_d = 32'(bypass_q);
        default:        rdata_d = RST_RDATA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q      <= '0;
      deb_prev_q <= '0;
      rise_en_q  <= N_PINS'(RST_REG);
      fall_en_q  <= N_PINS'(RST_REG);
      irq_en_q   <= N_PINS'(RST_REG);
      status_q   <= N_PINS'(RST_REG);
      bypass_q   <= N_PINS'(RST_REG);
      rdata_q    <= RST_RDATA;
    end else begin
      psc_q      <= psc_d;
      deb_prev_q <= deb;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_en_q   <= irq_en_d;
      status_q   <= status_d;
      bypass_q   <= bypass_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign gpio_deb  = deb;
  assign irq       = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Scenario bench for gpio_in_conditioner with DEB_DIV=4, DEB_SAMPLES=3.
module tb_gpio_in_conditioner;

  localparam int N_PINS = 32;
  localparam int DIV    = 4;
  localparam int SMP    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              bus_valid = 1'b0;
  logic              bus_we = 1'b0;
  logic [31:0]       bus_addr = '0;
  logic [31:0]       bus_wdata = '0;
  logic [31:0]       bus_rdata;
  logic [N_PINS-1:0] pad_in = '0;
  logic [N_PINS-1:0] gpio_deb;
  logic              irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  gpio_in_conditioner #(.N_PINS(N_PINS), .DEB_DIV(DIV), .DEB_SAMPLES(SMP)) dut (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .pad_in(pad_in), .gpio_deb(gpio_deb), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; pad_in = '0; bus_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    step();
    bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  // Expected value is queued by the caller before the strobe, popped after the data lands
  task automatic do_read(input logic [31:0] a, output logic [31:0] got, output logic [31:0] e);
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = a;
    step();
    bus_valid = 1'b0;
    got = bus_rdata;
    e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    apply_reset();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b want=0", irq); end
    n_cmp++; if (gpio_deb !== '0) begin n_err++; $display("FAIL reset_deb got=%h want=0", gpio_deb); end
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(32'h0);
      do_read(32'(k * 4), got, e);
      n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL reset_read off=%0h got=%h want=%h", k * 4, got, e); end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] got, e;
    logic seen = 1'b0;
    apply_reset();
    do_write(32'h08, 32'h1);
    do_write(32'h10, 32'h1);
    pad_in[0] = 1'b1;
    repeat (6) begin step(); seen |= gpio_deb[0]; end
    pad_in[0] = 1'b0;
    repeat (20) begin step(); seen |= gpio_deb[0]; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL glitch_deb got=%b want=0", seen); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq got=%b want=0", irq); end
    exp_q.push_back(32'h0);
    do_read(32'h14, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL glitch_status got=%h want=%h", got, e); end
  endtask

  task automatic test_debounce_irq();
    logic [31:0] got, e;
    int n = 0;
    apply_reset();
    do_write(32'h08, 32'h8);
    do_write(32'h10, 32'h8);
    pad_in[3] = 1'b1;
    while (n < 20 && gpio_deb[3] !== 1'b1) begin step(); n++; end
    // 2 sync edges + first tick (3..6) + (SMP-1)*DIV
    n_cmp++;
    if (n < 3 + (SMP - 1) * DIV || n > 3 + DIV * SMP)
      begin n_err++; $display("FAIL deb_latency got=%0d want=11..15", n); end
    step();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL deb_irq got=%b want=1", irq); end
    exp_q.push_back(32'h8);
    do_read(32'h14, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL deb_status got=%h want=%h", got, e); end
    do_write(32'h14, 32'h8);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq got=%b want=0", irq); end
    exp_q.push_back(32'h0);
    do_read(32'h14, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL w1c_status got=%h want=%h", got, e); end
  endtask

  task automatic test_collision();
    logic [31:0] got, e;
    apply_reset();
    do_write(32'h0C, 32'h20);
    do_write(32'h18, 32'h20);
    pad_in[5] = 1'b1;
    repeat (4) step();
    n_cmp++; if (gpio_deb[5] !== 1'b1) begin n_err++; $display("FAIL col_high got=%b want=1", gpio_deb[5]); end
    pad_in[5] = 1'b0;
    repeat (3) step();
    // fall is high now; the W1C lands on the same edge that sets the bit
    do_write(32'h14, 32'h20);
    exp_q.push_back(32'h20);
    do_read(32'h14, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL collision got=%h want=%h", got, e); end
    do_write(32'h10, 32'h20);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_en_set got=%b want=1", irq); end
    do_write(32'h10, 32'h0);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_mask got=%b want=0", irq); end
    exp_q.push_back(32'h20);
    do_read(32'h14, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL mask_keeps got=%h want=%h", got, e); end
    do_write(32'h14, 32'h20);
    exp_q.push_back(32'h0);
    do_read(32'h14, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL col_clear got=%h want=%h", got, e); end
  endtask

  task automatic test_bypass();
    logic [31:0] got, e;
    apply_reset();
    do_write(32'h18, 32'hFFFF_FFFF);
    pad_in = 32'hA5A5_0000;
    repeat (2) step();
    n_cmp++; if (gpio_deb !== '0) begin n_err++; $display("FAIL byp_early got=%h want=0", gpio_deb); end
    step();
    n_cmp++; if (gpio_deb !== 32'hA5A5_0000) begin n_err++; $display("FAIL byp_deb got=%h want=a5a50000", gpio_deb); end
    exp_q.push_back(32'hFFFF_FFFF);
    do_read(32'h18, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL byp_reg got=%h want=%h", got, e); end
    exp_q.push_back(32'h0);
    do_read(32'h1C, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL unmapped got=%h want=%h", got, e); end
    exp_q.push_back(32'hA5A5_0000);
    do_read(32'h00, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL in_raw got=%h want=%h", got, e); end
    exp_q.push_back(32'hA5A5_0000);
    do_read(32'h04, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL in_deb got=%h want=%h", got, e); end
    repeat (2) step();
    n_cmp++; if (bus_rdata !== 32'hA5A5_0000) begin n_err++; $display("FAIL rdata_hold got=%h want=a5a50000", bus_rdata); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, e;
    int n = 0;
    apply_reset();
    do_write(32'h08, 32'h4);
    pad_in[2] = 1'b1;
    // First tick lands on edge 3..6, so pin 2's counter is 1 when rst is sampled at edge 7
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (gpio_deb[2] !== 1'b0) begin n_err++; $display("FAIL mid_deb got=%b want=0", gpio_deb[2]); end
    while (n < 20 && gpio_deb[2] !== 1'b1) begin step(); n++; end
    // Prescaler restarts at 0: ticks at 4, 8, 12 after release
    n_cmp++; if (n != 4 * SMP) begin n_err++; $display("FAIL mid_redeb got=%0d want=%0d", n, 4 * SMP); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_irq got=%b want=0", irq); end
    exp_q.push_back(32'h0);
    do_read(32'h14, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL mid_status got=%h want=%h", got, e); end
    exp_q.push_back(32'h0);
    do_read(32'h08, got, e);
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL mid_rise_en got=%h want=%h", got, e); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_debounce_irq();
    test_collision();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/gpio_in_conditioner.md
# gpio_in_conditioner

Input-conditioning stage placed directly upstream of `multi_gpio`. It synchronises raw pad inputs and debounces each pin. The debounced word drives `multi_gpio.gpio_in`. The block also detects edges on debounced pins and raises a level interrupt to the RISC-V core. It uses the same single-beat `bus_valid`/`bus_we` register bus as `multi_gpio`, mapped in its own address window.

## Interface
- `N_PINS`, 32: number of conditioned pins (1..32).
- `DEB_DIV`, 1000: prescaler period, in clk cycles, between debounce sample ticks (≥2).
- `DEB_SAMPLES`, 4: consecutive ticks an input must differ from the debounced value before it is accepted (≥1).

- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `bus_valid`  in  1  bus access strobe, valid for one cycle.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  32  byte address; only `[4:2]` is decoded.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  registered read data.
- `pad_in`  in  N_PINS  raw asynchronous pad inputs.
- `gpio_deb`  out  N_PINS  debounced inputs; connects to `multi_gpio.gpio_in`.
- `irq`  out  1  level interrupt, equal to |(IRQ_STATUS & IRQ_EN).

## Operation
- Sync: two-flop synchroniser per pin; the second stage is called `sync`.
- Prescaler:
  - Counts 0..DEB_DIV-1 and wraps.
  - `tick` is high for one cycle when the count equals DEB_DIV-1.
- Per-pin debounce, evaluated on `tick` only:
  - If `sync == deb`, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches DEB_SAMPLES-1 while still differing, `deb <= sync` and the counter is cleared.
  - Counter width is clog2(DEB_SAMPLES)+1. The counter never wraps.
- Bypass: if BYPASS[i]=1, `deb[i] <= sync[i]` every cycle and counter i is held at 0.
- Edge detect: `deb_q` is `deb` delayed by one cycle.
  - rise = deb & ~deb_q.
  - fall = ~deb & deb_q.
- Status: STATUS[i] is set by (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]). It is cleared by writing 1 to that bit (W1C).
- Register map (offset = `bus_addr[4:2]`×4):
  - 0x00 IN_RAW (RO, `sync`)
  - 0x04 IN_DEB (RO)
  - 0x08 RISE_EN (RW)
  - 0x0C FALL_EN (RW)
  - 0x10 IRQ_EN (RW)
  - 0x14 IRQ_STATUS (RW1C)
  - 0x18 BYPASS (RW)
- Unmapped offset (0x1C): writes are ignored and reads return 0.
- Bits at and above N_PINS read as 0 and ignore writes.
- Reset values:
  - All registers, sync flops, counters, prescaler, `deb` and `deb_q` are 0.
  - `gpio_deb`=0, `bus_rdata`=0, `irq`=0.

## Timing
- Write: takes effect at the rising edge on which `bus_valid & bus_we` is sampled.
- Read:
  - `bus_rdata` is loaded at the edge sampling `bus_valid & ~bus_we`, giving 1-cycle latency.
  - It holds its value until the next read.
- Bypass path: a `pad_in` change is visible on `gpio_deb` after 3 rising edges.
- Debounced path: latency is 3 edges + wait for the next tick + (DEB_SAMPLES-1)×DEB_DIV cycles.
- A glitch shorter than DEB_SAMPLES consecutive ticks never reaches `gpio_deb`.
- Status bit is set 1 cycle after `deb` changes. `irq` is a registered-status combinational OR, so it also rises 1 cycle after the `deb` change.
- Simultaneous W1C and set on the same bit: set wins and the bit stays 1.
- Clearing IRQ_EN masks `irq` in the same cycle the write lands; STATUS is kept.
- Enabling IRQ_EN with STATUS already 1 asserts `irq` the cycle after the write.
- Toggling BYPASS from 1 to 0 clears nothing. The counter restarts from 0.
- `rst` asserted mid-debounce: every state element returns to its reset value at that edge. No edge or status is generated by the reset itself.

## Structure
- Package `gpio_cond_pkg`:
  - register offset constants: `OFF_IN_RAW` .. `OFF_BYPASS`
  - `ADDR_IDX_W`=3
  - reset value constants
- Sub-module `gpio_debounce_bit`:
  - one pin: synchroniser, counter, `deb` flop, and the bypass mux
  - generated N_PINS times
  - shares `tick` from the top-level prescaler
- Top level holds the prescaler, edge/status logic, register file and read mux.

## Test plan
Bench parameters: DEB_DIV=4, DEB_SAMPLES=3.
- Reset: hold `rst` 3 cycles, then read every offset. Expect 0 everywhere, `irq`=0 and `gpio_deb`=0.
- Glitch rejection: `pad_in[0]`=1 for 6 cycles then 0. Expect `gpio_deb[0]` to stay 0, STATUS=0 and `irq`=0.
- Debounce and interrupt:
  - Setup: write RISE_EN=0x8 and IRQ_EN=0x8, then hold `pad_in[3]`=1.
  - `gpio_deb[3]` rises within 3+4×3 cycles.
  - One cycle later, STATUS reads 0x8 and `irq`=1.
  - Write 0x8 to 0x14: expect `irq`=0 the next cycle.
- Collision: schedule a W1C to STATUS[5] in the same cycle as a falling edge on pin 5 with FALL_EN[5]=1. Expect STATUS[5]=1 afterward.
- Bypass and passthrough:
  - Setup: BYPASS=0xFFFFFFFF, `pad_in`=0xA5A5_0000.
  - `gpio_deb`=0xA5A5_0000 after 3 edges.
  - Read 0x04 returns 0xA5A5_0000 one cycle after the read strobe.
  - Read 0x1C returns 0.
- Reset mid-debounce: assert `rst` while pin 2's counter is at 1. Expect counter 0, `gpio_deb[2]`=0 and STATUS=0. After release, a fresh full 3-tick debounce is required.
